// File: rtl/encoder_stage_sched.sv
// +----------------------------------------------------------------------------+
// | encoder_stage_sched: sequences the encoder stages over one ping-pong line  |
// | memory. Optional stage watchdog enabled by macro STAGE_TIMEOUT_EN.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module encoder_stage_sched #(
  parameter int NUM_STAGES = 5,
  parameter int LINES      = 64,
  parameter int LINE_W     = 25,
  parameter int CNT_W      = 7,
  parameter int TIMEOUT    = 256
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic                         err,
  output logic [NUM_STAGES-1:0]        stage_start,
  input  logic [NUM_STAGES-1:0]        stage_done,
  input  logic [NUM_STAGES-1:0]        stage_wr_en,
  input  logic [NUM_STAGES*CNT_W-1:0]  stage_cnt,
  input  logic [NUM_STAGES*LINE_W-1:0] stage_wr_data,
  output logic [2:0]                   active_idx,
  output logic [5:0]                   mem_rd_addr,
  output logic                         mem_rd_bank,
  output logic                         mem_wr_en,
  output logic [5:0]                   mem_wr_addr,
  output logic                         mem_wr_bank,
  output logic [LINE_W-1:0]            mem_wr_data,
  output logic                         result_bank
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_RUN    = 3'd2,
    S_NEXT   = 3'd3,
    S_FIN    = 3'd4
  } state_t;

  localparam logic [2:0]  c_last      = 3'(NUM_STAGES - 1);
  localparam logic [6:0]  c_lines     = 7'(LINES);
  localparam logic [31:0] c_num_stage = 32'(NUM_STAGES);

  state_t                  state_q;
  logic [2:0]              active_idx_q;
  logic [6:0]              wr_cnt_q;
  logic [6:0]              wr_cnt_d;
  logic                    err_q;
  logic                    busy_q;
  logic                    done_q;
  logic [NUM_STAGES-1:0]   stage_start_q;

  logic                    w_sel_done;
  logic                    w_sel_wr_en;
  logic [CNT_W-1:0]        w_sel_cnt;
  logic [LINE_W-1:0]       w_sel_data;
  logic                    w_wr_hit;
  logic                    w_cnt_unused;

  always_comb begin
    w_sel_done  = 1'b0;
    w_sel_wr_en = 1'b0;
    w_sel_cnt   = '0;
    w_sel_data  = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      if (active_idx_q == 3'(k)) begin
        w_sel_done  = stage_done[k];
        w_sel_wr_en = stage_wr_en[k];
        w_sel_cnt   = stage_cnt[k*CNT_W +: CNT_W];
        w_sel_data  = stage_wr_data[k*LINE_W +: LINE_W];
      end
    end
  end

  assign w_cnt_unused = ^w_sel_cnt[CNT_W-1:6];
  assign w_wr_hit     = (state_q == S_RUN) && w_sel_wr_en;

  // Write count saturates so a runaway stage cannot wrap back to LINES.
  always_comb begin
    if (wr_cnt_q >= c_lines) begin
      wr_cnt_d = c_lines;
    end else begin
      wr_cnt_d = wr_cnt_q + {6'd0, w_wr_hit};
    end
  end

`ifdef STAGE_TIMEOUT_EN
  localparam logic [8:0] c_timeout = 9'(TIMEOUT);
  logic [8:0] wd_q;
  logic       w_wd_expire;

  assign w_wd_expire = (wd_q + 9'd1) == c_timeout;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_q <= '0;
    end else if (state_q == S_LAUNCH) begin
      wd_q <= '0;
    end else if (state_q == S_RUN) begin
      wd_q <= wd_q + 9'd1;
    end
  end
`else
  localparam logic [8:0] c_timeout = 9'(TIMEOUT);
  logic w_timeout_unused;
  logic w_wd_expire;

  assign w_timeout_unused = ^c_timeout;
  assign w_wd_expire      = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      active_idx_q  <= '0;
      wr_cnt_q      <= '0;
      err_q         <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      stage_start_q <= '0;
    end else begin
      stage_start_q <= '0;
      done_q        <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            err_q         <= 1'b0;
            active_idx_q  <= '0;
            busy_q        <= 1'b1;
            stage_start_q <= NUM_STAGES'(1);
            state_q       <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          wr_cnt_q <= '0;
          state_q  <= S_RUN;
        end
        S_RUN: begin
          wr_cnt_q <= wr_cnt_d;
          if (w_sel_done) begin
            if (wr_cnt_d != c_lines) begin
              err_q <= 1'b1;
            end
            state_q <= S_NEXT;
          end else if (w_wd_expire) begin
            err_q   <= 1'b1;
            done_q  <= 1'b1;
            state_q <= S_FIN;
          end
        end
        S_NEXT: begin
          if (active_idx_q == c_last) begin
            done_q  <= 1'b1;
            state_q <= S_FIN;
          end else begin
            active_idx_q  <= active_idx_q + 3'd1;
            stage_start_q <= NUM_STAGES'(1) << (active_idx_q + 3'd1);
            state_q       <= S_LAUNCH;
          end
        end
        S_FIN: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign stage_start = stage_start_q;
  assign active_idx  = active_idx_q;
  assign mem_rd_addr = w_sel_cnt[5:0];
  assign mem_wr_addr = w_sel_cnt[5:0];
  assign mem_rd_bank = active_idx_q[0];
  assign mem_wr_bank = ~active_idx_q[0];
  assign mem_wr_en   = w_wr_hit;
  assign mem_wr_data = w_sel_data;
  assign result_bank = c_num_stage[0];

endmodule

`default_nettype wire
